// File: rtl/alu_pkg.sv
// Shared definitions for param_seq_alu: opcodes, FSM encoding and the flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/seq_shift_add_mult.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     partial;

  // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
  assign partial = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign product = prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand <= a;
        prod  <= {{WIDTH{1'b0}}, b};
        cnt   <= CW'(WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        prod <= {partial, prod[WIDTH-1:1]};
        cnt  <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/param_seq_alu.sv
// Registered valid/ready ALU with multi-cycle multiply.
// Define PARAM_SEQ_ALU_SAT_EN to saturate ADD/SUB/INC/DEC on signed overflow.
module param_seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic               accept, start_mul, start_single, load_mul;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     ext;
  logic [SHW-1:0]     sh;
  flags_t             alu_flags, flags_q;

  assign in_ready     = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid    = (state == DONE);
  assign accept       = in_valid & in_ready;
  assign start_mul    = accept & (op == OP_MUL);
  assign start_single = accept & (op != OP_MUL);

  seq_shift_add_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_mul  = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = start_mul ? MUL : DONE;
      MUL: begin
        if (mul_done & ~mul_busy) begin
          load_mul  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: if (out_ready) state_nxt = in_valid ? (start_mul ? MUL : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res   = '0;
    ext       = '0;
    alu_flags = '0;
    sh        = b[SHW-1:0];
    case (op)
      OP_ADD: begin
        ext                = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        alu_res            = ext[WIDTH-1:0];
        alu_flags.carry    = ext[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext                = {1'b0, a} - {1'b0, b};
        alu_res            = ext[WIDTH-1:0];
        alu_flags.carry    = ext[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP: alu_res = {{(WIDTH-3){1'b0}}, a > b, a == b, a < b};
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOT: alu_res = ~a;
      OP_INC: begin
        ext                = {1'b0, a} + (WIDTH+1)'(1);
        alu_res            = ext[WIDTH-1:0];
        alu_flags.carry    = ext[WIDTH];
        alu_flags.overflow = ~a[WIDTH-1] & alu_res[WIDTH-1];
      end
      OP_DEC: begin
        ext                = {1'b0, a} - (WIDTH+1)'(1);
        alu_res            = ext[WIDTH-1:0];
        alu_flags.carry    = ext[WIDTH];
        alu_flags.overflow = a[WIDTH-1] & ~alu_res[WIDTH-1];
      end
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        // The extra top bit catches the last bit shifted out.
        ext             = {1'b0, a} << sh;
        alu_res         = ext[WIDTH-1:0];
        alu_flags.carry = ext[WIDTH];
      end
      OP_SHR: alu_res = a >> sh;
      OP_MUL: ;
      default: alu_flags.illegal = 1'b1;
    endcase
`ifdef PARAM_SEQ_ALU_SAT_EN
    // Overflow direction always follows the sign of operand a for these four ops.
    if (alu_flags.overflow)
      alu_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    // wrap-around arithmetic only
`endif
    alu_flags.zero     = (alu_res == '0) & ~alu_flags.illegal;
    alu_flags.negative = alu_res[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      flags_q   <= '0;
    end else if (start_single) begin
      result    <= alu_res;
      result_hi <= '0;
      flags_q   <= alu_flags;
    end else if (load_mul) begin
      result           <= mul_prod[WIDTH-1:0];
      result_hi        <= mul_prod[2*WIDTH-1:WIDTH];
      flags_q          <= '0;
      flags_q.zero     <= (mul_prod == '0);
      flags_q.negative <= mul_prod[2*WIDTH-1];
    end
  end

  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;
  assign illegal  = flags_q.illegal;

endmodule

// File: tb/tb_param_seq_alu.sv
// Directed self-checking bench for param_seq_alu at WIDTH=8.
module tb_param_seq_alu;
  import alu_pkg::*;

  localparam int WIDTH = 8;
`ifdef PARAM_SEQ_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, cin, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, result, result_hi;
  logic [3:0]       op;
  logic             carry, overflow, zero, negative, illegal;
  logic [4:0]       fl;

  int n_checks = 0;
  int n_errors = 0;

  assign fl = {carry, overflow, zero, negative, illegal};

  param_seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // flags order: {carry, overflow, zero, negative, illegal}
  task automatic run_single(input string tag, input logic [3:0] o, input logic [7:0] va,
                            input logic [7:0] vb, input logic vc,
                            input logic [7:0] exp_res, input logic [4:0] exp_fl);
    @(negedge clk);
    op = o; a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({tag, "_res"}, {out_valid, result_hi, result}, {1'b1, 8'h00, exp_res});
    chk({tag, "_flg"}, fl, exp_fl);
  endtask

  task automatic run_mul(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] exp_prod, input logic [4:0] exp_fl);
    int lat;
    bit ir_bad;
    @(negedge clk);
    op = OP_MUL; a = va; b = vb; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    // junk request that must be ignored while multiplying and while held in DONE
    op = OP_ADD; a = 8'h01; b = 8'h01; out_ready = 1'b0;
    lat = 0;
    ir_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_lat"}, lat, WIDTH + 1);
    chk({tag, "_rdy_busy"}, ir_bad, 0);
    chk({tag, "_prod"}, {result_hi, result}, exp_prod);
    chk({tag, "_flg"}, fl, exp_fl);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; op = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", {out_valid, result_hi, result, fl}, '0);
    chk("rst_rdy", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ADD overflow, then hold in DONE with a pending request
    @(negedge clk);
    op = OP_ADD; a = 8'h7F; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("add_ovf_res", {out_valid, result}, {1'b1, (SAT ? 8'h7F : 8'h80)});
    chk("add_ovf_flg", fl, SAT ? 5'b01000 : 5'b01010);
    a = 8'h02; b = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold", {out_valid, in_ready, result, fl},
          {1'b1, 1'b0, (SAT ? 8'h7F : 8'h80), (SAT ? 5'b01000 : 5'b01010)});
    end
    out_ready = 1'b1;
    #1 chk("b2b_rdy", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b_res", {out_valid, result, fl}, {1'b1, 8'h05, 5'b00000});
    @(posedge clk);
    #1 chk("idle_ret", {out_valid, in_ready}, 2'b01);

    run_single("sub",     OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 5'b10010);
    run_single("cmp_eq",  OP_CMP, 8'h05, 8'h05, 1'b0, 8'h02, 5'b00000);
    run_single("cmp_lt",  OP_CMP, 8'h03, 8'h09, 1'b0, 8'h01, 5'b00000);
    run_single("cmp_gt",  OP_CMP, 8'h09, 8'h03, 1'b0, 8'h04, 5'b00000);
    run_single("and",     OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 5'b00000);
    run_single("or",      OP_OR,  8'hF0, 8'h0F, 1'b0, 8'hFF, 5'b00010);
    run_single("not",     OP_NOT, 8'h0F, 8'h00, 1'b0, 8'hF0, 5'b00010);
    run_single("xor",     OP_XOR, 8'hAA, 8'hFF, 1'b0, 8'h55, 5'b00000);
    run_single("inc_wrap", OP_INC, 8'hFF, 8'h00, 1'b0, 8'h00, 5'b10100);
    run_single("inc_ovf", OP_INC, 8'h7F, 8'h00, 1'b0, SAT ? 8'h7F : 8'h80,
               SAT ? 5'b01000 : 5'b01010);
    run_single("dec_zero", OP_DEC, 8'h00, 8'h00, 1'b0, 8'hFF, 5'b10010);
    run_single("dec_ovf", OP_DEC, 8'h80, 8'h00, 1'b0, SAT ? 8'h80 : 8'h7F,
               SAT ? 5'b01010 : 5'b01000);
    run_single("sub_ovf", OP_SUB, 8'h80, 8'h01, 1'b0, SAT ? 8'h80 : 8'h7F,
               SAT ? 5'b01010 : 5'b01000);
    run_single("add_cin", OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h01, 5'b10000);
    run_single("add_zero", OP_ADD, 8'h00, 8'h00, 1'b0, 8'h00, 5'b00100);
    run_single("shl1",    OP_SHL, 8'h81, 8'h01, 1'b0, 8'h02, 5'b10000);
    run_single("shl0",    OP_SHL, 8'h81, 8'h00, 1'b0, 8'h81, 5'b00010);
    run_single("shl2",    OP_SHL, 8'h40, 8'h02, 1'b0, 8'h00, 5'b10100);
    run_single("shr3",    OP_SHR, 8'h81, 8'h03, 1'b0, 8'h10, 5'b00000);
    run_single("illegal", 4'd13,  8'h12, 8'h34, 1'b1, 8'h00, 5'b00001);

    run_mul("mul_ff", 8'hFF, 8'hFF, 16'hFE01, 5'b00010);
    run_mul("mul_small", 8'h0C, 8'h0A, 16'h0078, 5'b00000);
    run_mul("mul_zero", 8'h00, 8'h37, 16'h0000, 5'b00100);

    // reset during the 4th multiply cycle
    run_single("pre_rst", OP_OR, 8'h11, 8'h22, 1'b0, 8'h33, 5'b00000);
    @(negedge clk);
    op = OP_MUL; a = 8'h0C; b = 8'h0A; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_rst_out", {out_valid, result_hi, result, fl}, '0);
    chk("midmul_rst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_single("post_rst_add", OP_ADD, 8'h02, 8'h03, 1'b0, 8'h05, 5'b00000);
    run_mul("post_rst_mul", 8'h10, 8'h10, 16'h0100, 5'b00000);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_seq_alu.md
Name: param_seq_alu

Overview:
- Registered, handshaked N-bit ALU; next generation of the lab 4-bit combinational ALU.
- Widens the datapath via WIDTH, adds a 4-bit opcode space with XOR, shifts and multi-cycle unsigned multiply, and produces carry/overflow/zero/negative flags.
- Valid/ready on both sides so it can sit between operand-fetch and writeback stages of the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (4..32).
- SHW, $clog2(WIDTH), shift-amount width. Derived: localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; SHL/SHR use b[SHW-1:0] as the shift amount.
- cin  in  1  carry-in, used by ADD only.
- op  in  4  opcode (see Behaviour).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result, or low half of the product.
- result_hi  out  WIDTH  high half of the product; 0 for all other ops.
- carry  out  1  carry-out, borrow, or shifted-out bit.
- overflow  out  1  signed overflow.
- zero  out  1  full result is 0.
- negative  out  1  MSB of the full result.
- illegal  out  1  op was 12..15.

Behaviour:
- Opcodes:
  - 0 ADD: a+b+cin.
  - 1 SUB: a-b.
  - 2 CMP: result[0]=a<b, [1]=a==b, [2]=a>b (unsigned); other bits 0.
  - 3 AND.
  - 4 OR.
  - 5 NOT: ~a.
  - 6 INC: a+1.
  - 7 DEC: a-1.
  - 8 XOR.
  - 9 SHL: a<<b[SHW-1:0].
  - 10 SHR: a>>b[SHW-1:0], logical.
  - 11 MUL: unsigned a*b giving {result_hi,result}.
  - 12-15: illegal. Result 0, illegal=1, other flags 0, latency 1.
- Arithmetic is modulo 2^WIDTH on result.
- Flags:
  - carry: ADD carry-out; SUB/DEC borrow (a<b unsigned, or a==0 for DEC); INC carry-out; SHL the last bit shifted out (0 if shift amount 0); 0 otherwise.
  - overflow: two's-complement overflow for ADD/SUB/INC/DEC; 0 otherwise. Never high-Z.
  - zero: {result_hi,result}==0.
  - negative: result_hi[WIDTH-1] for MUL, result[WIDTH-1] otherwise.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid, capture a, b, cin, op. MUL goes to MUL; any other op computes and registers result and flags, then goes to DONE.
  - MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then DONE. in_ready=0. in_valid is ignored.
  - DONE: out_valid=1; result and flags held stable until out_ready.
    - out_ready=0: stay in DONE.
    - out_ready=1 and in_valid=1: in_ready=1 this cycle. Accept the new operation in the same cycle (back-to-back). Single-cycle op: remain DONE with new values. MUL: go to MUL.
    - out_ready=1 and in_valid=0: go to IDLE.
- Latency (accept edge to out_valid): 1 cycle for single-cycle ops, WIDTH+1 for MUL.
- Throughput: 1 op/cycle for single-cycle ops when out_ready is held high.
- in_ready is combinational: (state==IDLE) | (state==DONE & out_ready).
- Reset (async, any state, including mid-MUL): state=IDLE. out_valid, result, result_hi, carry, overflow, zero, negative and illegal all 0. Any in-progress multiply is discarded.

Optional Feature:
- Macro: PARAM_SEQ_ALU_SAT_EN.
- Defined: ADD/SUB/INC/DEC saturate to the signed limits 0x7F.. / 0x80.. on signed overflow; overflow still reports 1; carry is unchanged.
- Undefined: wrap-around arithmetic only, no saturation logic present.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD..OP_MUL;
  - FSM state encoding: IDLE=2'd0, MUL=2'd1, DONE=2'd2;
  - flag bundle struct {carry, overflow, zero, negative, illegal}.
- Sub-module seq_shift_add_mult:
  - parametrised by WIDTH; start/busy/done interface; 2*WIDTH product output;
  - holds the multiplier shift register and bit counter.
- Top level holds the FSM, operand registers, combinational single-cycle datapath and output registers.

Test Plan:
- WIDTH=8. ADD a=0x7F, b=0x01, cin=0 -> result=0x80, overflow=1, carry=0, negative=1, out_valid 1 cycle after accept.
- SUB a=0x03, b=0x05 -> result=0xFE, carry=1, overflow=0. CMP a=5, b=5 -> result=0x02, zero=0.
- MUL a=0xFF, b=0xFF -> {result_hi,result}=0xFE01, out_valid exactly 9 cycles after accept, in_ready=0 during MUL.
- out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 with a new ADD pending -> accepted same cycle, new result next cycle.
- rst_n pulsed low in the 4th MUL cycle -> all outputs 0 immediately. After release, in_ready=1 and the next ADD 2+3 gives 5.
- op=13 -> illegal=1, result=0. SHL a=0x81, b=1 -> result=0x02, carry=1. With PARAM_SEQ_ALU_SAT_EN: ADD 0x7F+0x01 -> result=0x7F, overflow=1.
